store_narrow: RTL and testbench
===============================

# store_narrow

Store-side narrowing unit for the multi-cycle CPU: the write-direction counterpart of the load-path immediate/data extender. It accepts a 32-bit store request (byte, halfword or word) from the control unit and writes the requested bytes to a byte-wide data memory, one byte per clock. Busy/Done handshakes hold the control FSM in its MEM state until the last byte has been written.

## Interface
- ADDR_W, 32, width of the store address and of MemAddr

- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  store request; sampled only in IDLE
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- Addr  in  ADDR_W  byte address of the first byte
- WData  in  32  register data; the low Size bytes are stored
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle completion pulse
- MemWr  out  1  byte-memory write enable
- MemAddr  out  ADDR_W  byte-memory address
- MemByte  out  8  byte-memory write data
- AlignErr  out  1  misalignment flag, pulses with Done; tied 0 when the feature is compiled out

## Operation
- States: IDLE, WRITE, DONE.
- IDLE + Start:
  - latch Addr, WData and Size;
  - set count k = 0 and N = 1, 2 or 4 bytes;
  - go to WRITE.
- IDLE + Start with Size = 11: go directly to DONE. No MemWr is asserted and AlignErr = 0.
- WRITE, each cycle:
  - MemWr = 1, MemAddr = base + k (mod 2^ADDR_W), MemByte = WData[8k+7:8k] (little-endian).
  - When k = N−1, go to DONE; otherwise k increments.
- DONE: Done = 1 for exactly one cycle, then return to IDLE.
- Start is ignored in WRITE and DONE. A request is accepted only when Busy = 0. The requester holds Start until it sees Busy.
- Latched operands are isolated from input changes after acceptance.
- Address wrap: base + k wraps modulo 2^ADDR_W. Example: a halfword at 0xFFFFFFFF writes 0xFFFFFFFF, then 0x00000000.
- Reset, at any time including mid-WRITE:
  - state → IDLE; the remaining bytes are never written;
  - Busy, Done, MemWr, AlignErr = 0; MemAddr = 0; MemByte = 0.

## Timing
- All outputs are registered from state.
- Start accepted at edge 0.
- Byte writes appear in cycles 1..N, one byte per cycle. MemWr is a contiguous N-cycle pulse.
- Done appears in cycle N+1. Busy is high in cycles 1..N+1.
- Total latency from Start to Done is N+1 cycles: 2 (byte), 3 (half), 5 (word). A reserved Size takes 1 cycle.
- The next request can be accepted at the edge following Done (cycle N+2), giving a back-to-back throughput of N+2 cycles per store.

## Configuration
- STORE_NARROW_ALIGN_CHECK_EN
  - Defined:
    - halfword with Addr[0] = 1, or word with Addr[1:0] ≠ 00, is misaligned;
    - a misaligned request goes IDLE → DONE with no MemWr;
    - AlignErr = 1 together with Done for one cycle.
  - Undefined:
    - no alignment check; misaligned stores write byte by byte at consecutive addresses;
    - AlignErr is constant 0.

## Test plan
- Byte store: Size = 00, Addr = 0x10, WData = 0xA1B2C3D4 → one MemWr in cycle 1 at 0x10 with data 0xD4; Done in cycle 2; Busy high in cycles 1–2.
- Word store: Size = 10, Addr = 0x20, WData = 0x11223344 → MemWr at 0x20/0x44, 0x21/0x33, 0x22/0x22, 0x23/0x11 in cycles 1–4; Done in cycle 5.
- Halfword store at Addr = 0x31, WData = 0x0000BEEF:
  - macro undefined → writes 0x31/0xEF and 0x32/0xBE; Done in cycle 3; AlignErr = 0;
  - macro defined → no MemWr; Done and AlignErr in cycle 1.
- Start re-asserted during WRITE of a word store with different Addr/WData → ignored; original four bytes written unchanged; the new request is accepted only after Done.
- Reset asserted in cycle 2 of a word store → outputs zero immediately (asynchronous); only byte 0 was written; the FSM is IDLE after reset is released.
- Size = 11 → no MemWr; Done in cycle 1; AlignErr = 0. Halfword at 0xFFFFFFFF with the macro undefined → writes to 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/store_narrow.sv
// Store-side narrowing unit: writes the low 1, 2 or 4 bytes of a store to a byte-wide memory, one byte per clock.
// Optional alignment check is enabled by defining STORE_NARROW_ALIGN_CHECK_EN.
module store_narrow #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WData,
    output logic              Busy,
    output logic              Done,
    output logic              MemWr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemByte,
    output logic              AlignErr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        last_q, last_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              memwr_q, memwr_d;
    logic [ADDR_W-1:0] memaddr_q, memaddr_d;
    logic [7:0]        membyte_q, membyte_d;
    logic [1:0]        k_nxt;

`ifdef STORE_NARROW_ALIGN_CHECK_EN
    logic alignerr_q, alignerr_d;
    logic misalign;

    assign misalign = ((Size == 2'b01) && Addr[0]) ||
                      ((Size == 2'b10) && (Addr[1:0] != 2'b00));
`endif

    assign k_nxt = k_q + 2'd1;

    // Outputs are computed for the state being entered so they appear registered in the following cycle.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        wdata_d   = wdata_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        memwr_d   = 1'b0;
        memaddr_d = '0;
        membyte_d = '0;
`ifdef STORE_NARROW_ALIGN_CHECK_EN
        alignerr_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Size == 2'b11) begin
                        state_d = S_DONE;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                    end
`ifdef STORE_NARROW_ALIGN_CHECK_EN
                    else if (misalign) begin
                        state_d    = S_DONE;
                        busy_d     = 1'b1;
                        done_d     = 1'b1;
                        alignerr_d = 1'b1;
                    end
`endif
                    else begin
                        state_d   = S_WRITE;
                        wdata_d   = WData;
                        k_d       = 2'd0;
                        case (Size)
                            2'b00:   last_d = 2'd0;
                            2'b01:   last_d = 2'd1;
                            default: last_d = 2'd3;
                        endcase
                        busy_d    = 1'b1;
                        memwr_d   = 1'b1;
                        memaddr_d = Addr;
                        membyte_d = WData[7:0];
                    end
                end
            end
            S_WRITE: begin
                busy_d = 1'b1;
                if (k_q == last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    k_d       = k_nxt;
                    memwr_d   = 1'b1;
                    memaddr_d = memaddr_q + ADDR_W'(1);
                    membyte_d = wdata_q[{k_nxt, 3'b000} +: 8];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            k_q       <= 2'd0;
            last_q    <= 2'd0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            memwr_q   <= 1'b0;
            memaddr_q <= '0;
            membyte_q <= '0;
`ifdef STORE_NARROW_ALIGN_CHECK_EN
            alignerr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            last_q    <= last_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            memwr_q   <= memwr_d;
            memaddr_q <= memaddr_d;
            membyte_q <= membyte_d;
`ifdef STORE_NARROW_ALIGN_CHECK_EN
            alignerr_q <= alignerr_d;
`endif
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign MemWr   = memwr_q;
    assign MemAddr = memaddr_q;
    assign MemByte = membyte_q;

`ifdef STORE_NARROW_ALIGN_CHECK_EN
    assign AlignErr = alignerr_q;
`else
    assign AlignErr = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Scoreboard bench for store_narrow: a request model queues expected byte writes and completions, a monitor checks them.
module tb_store_narrow;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Size;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Busy, Done, MemWr, AlignErr;
    logic [31:0] MemAddr;
    logic [7:0]  MemByte;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [7:0]  data;
        bit          ae;
    } ev_t;

    ev_t exp_q[$];

    store_narrow #(.ADDR_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Size(Size), .Addr(Addr), .WData(WData),
        .Busy(Busy), .Done(Done), .MemWr(MemWr), .MemAddr(MemAddr), .MemByte(MemByte),
        .AlignErr(AlignErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a store of N = 2^Size bytes writes byte i of the data to address base+i; completion follows.
    function automatic int model_push(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        int  n;
        bit  bad;
        if (sz == 2'b11) begin
            e = '{is_done: 1'b1, addr: 32'h0, data: 8'h0, ae: 1'b0};
            exp_q.push_back(e);
            return 1;
        end
        n = 1 << sz;
        bad = 1'b0;
`ifdef STORE_NARROW_ALIGN_CHECK_EN
        bad = (a % n) != 0;
`endif
        if (bad) begin
            e = '{is_done: 1'b1, addr: 32'h0, data: 8'h0, ae: 1'b1};
            exp_q.push_back(e);
            return 1;
        end
        for (int i = 0; i < n; i++) begin
            e = '{is_done: 1'b0, addr: a + 32'(i), data: 8'((d >> (8 * i)) & 32'hFF), ae: 1'b0};
            exp_q.push_back(e);
        end
        e = '{is_done: 1'b1, addr: 32'h0, data: 8'h0, ae: 1'b0};
        exp_q.push_back(e);
        return n + 1;
    endfunction

    always @(negedge CLK) begin
        ev_t e;
        if (!Reset) begin
            if (MemWr && Done) begin
                tests++;
                fails++;
                $display("FAIL overlap: MemWr and Done both 1 at %0t", $time);
            end else if (MemWr || Done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: MemWr=%0b Done=%0b addr=0x%0h with nothing expected at %0t",
                             MemWr, Done, MemAddr, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (MemWr) begin
                        chk("kind_write", 32'(e.is_done), 32'd0);
                        chk("mem_addr", MemAddr, e.addr);
                        chk("mem_byte", 32'(MemByte), 32'(e.data));
                    end else begin
                        chk("kind_done", 32'(e.is_done), 32'd1);
                        chk("align_err", 32'(AlignErr), 32'(e.ae));
                    end
                    chk("busy_active", 32'(Busy), 32'd1);
                end
            end else begin
                chk("align_err_idle", 32'(AlignErr), 32'd0);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after Done.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input bit interfere);
        int lat;
        int exp_lat;
        exp_lat = model_push(sz, a, d);
        Start = 1'b1; Size = sz; Addr = a; WData = d;
        @(negedge CLK);
        chk("busy_after_accept", 32'(Busy), 32'd1);
        lat = 1;
        while (!Done && lat < 20) begin
            Start = interfere; Size = 2'($urandom); Addr = $urandom; WData = $urandom;
            @(negedge CLK);
            lat++;
        end
        Start = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        @(negedge CLK);
        chk("busy_after_done", 32'(Busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Size = 2'b00; Addr = '0; WData = '0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_memwr", 32'(MemWr), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_membyte", 32'(MemByte), 32'd0);
        chk("rst_alignerr", 32'(AlignErr), 32'd0);
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        do_store(2'b00, 32'h10, 32'hA1B2C3D4, 1'b0);
        do_store(2'b10, 32'h20, 32'h11223344, 1'b0);
        do_store(2'b01, 32'h31, 32'h0000BEEF, 1'b0);
        do_store(2'b10, 32'h40, 32'hCAFEF00D, 1'b1);
        do_store(2'b11, 32'h50, 32'h12345678, 1'b0);
        do_store(2'b01, 32'hFFFFFFFF, 32'h00005A6B, 1'b0);

        // Reset during cycle 2 of a word store: only byte 0 reaches memory.
        begin
            ev_t e;
            e = '{is_done: 1'b0, addr: 32'h60, data: 8'h88, ae: 1'b0};
            exp_q.push_back(e);
            Start = 1'b1; Size = 2'b10; Addr = 32'h60; WData = 32'h55667788;
            @(negedge CLK);
            Start = 1'b0;
            @(posedge CLK);
            #2 Reset = 1'b1;
            #1;
            chk("midrst_busy", 32'(Busy), 32'd0);
            chk("midrst_memwr", 32'(MemWr), 32'd0);
            chk("midrst_memaddr", MemAddr, 32'd0);
            chk("midrst_membyte", 32'(MemByte), 32'd0);
            repeat (2) @(negedge CLK);
            Reset = 1'b0;
            @(negedge CLK);
            chk("postrst_busy", 32'(Busy), 32'd0);
            chk("postrst_pending", 32'(exp_q.size()), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 2))) : $urandom;
            do_store(sz, a, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge CLK);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
